// File: rtl/alu_seq_unit.sv
// Handshaked EX-stage ALU: registered result + NZCV, one op per cycle over valid/ready.
// Define ALU_SEQ_MUL_EN to add the iterative shift-add MUL (cmd 4'hA) and its BUSY state.
module alu_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CMD_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CMD_W-1:0] exe_cmd,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  input  logic             v_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       sr,
  output logic             dbg_busy
);
  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never waits on ready, and a held output stays stable until it is taken.
  localparam logic [CMD_W-1:0] CMD_MOV = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_ADC = CMD_W'(3);
  localparam logic [CMD_W-1:0] CMD_SUB = CMD_W'(4);
  localparam logic [CMD_W-1:0] CMD_SBC = CMD_W'(5);
  localparam logic [CMD_W-1:0] CMD_AND = CMD_W'(6);
  localparam logic [CMD_W-1:0] CMD_ORR = CMD_W'(7);
  localparam logic [CMD_W-1:0] CMD_EOR = CMD_W'(8);
  localparam logic [CMD_W-1:0] CMD_MVN = CMD_W'(9);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_sr;
  logic [WIDTH-1:0] w_b_add, w_res;
  logic [WIDTH:0]   w_sum;
  logic             w_c_add, w_arith, w_is_mul, w_c, w_v, w_accept;
  logic [3:0]       w_sr;

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign sr        = r_sr;
  assign w_accept  = in_valid & in_ready;

  // Undefined commands fall through with w_res=0, giving sr={0,1,c_in,v_in} for free.
  always_comb begin
    w_b_add  = in2;
    w_c_add  = 1'b0;
    w_arith  = 1'b0;
    w_is_mul = 1'b0;
    w_res    = '0;
    case (exe_cmd)
      CMD_MOV: w_res = in2;
      CMD_MVN: w_res = ~in2;
      CMD_ADD: w_arith = 1'b1;
      CMD_ADC: begin w_arith = 1'b1; w_c_add = c_in; end
      CMD_SUB: begin w_arith = 1'b1; w_b_add = ~in2; w_c_add = 1'b1; end
      CMD_SBC: begin w_arith = 1'b1; w_b_add = ~in2; w_c_add = c_in; end
      CMD_AND: w_res = in1 & in2;
      CMD_ORR: w_res = in1 | in2;
      CMD_EOR: w_res = in1 ^ in2;
`ifdef ALU_SEQ_MUL_EN
      CMD_W'(10): w_is_mul = 1'b1;
`endif
      default: w_res = '0;
    endcase
    w_sum = {1'b0, in1} + {1'b0, w_b_add} + {{WIDTH{1'b0}}, w_c_add};
    if (w_arith) w_res = w_sum[WIDTH-1:0];
    w_c  = w_arith ? w_sum[WIDTH] : c_in;
    w_v  = w_arith ? ((in1[WIDTH-1] == w_b_add[WIDTH-1]) && (w_res[WIDTH-1] != in1[WIDTH-1])) : v_in;
    w_sr = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, r_mcand, r_mplier, w_acc_nxt;
  logic [CNT_W-1:0] r_count;
  logic             r_mc, r_mv, w_mul_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // The last shift-add step and the result load share one edge, so latency is WIDTH+1.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) w_state_nxt = S_IDLE;
    else begin
      case (r_state)
        S_IDLE: if (w_accept && w_is_mul) w_state_nxt = S_BUSY;
        S_BUSY: if (r_count == CNT_W'(WIDTH - 1)) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready) && !flush;
    dbg_busy   = (r_state == S_BUSY);
    w_mul_done = (r_state == S_BUSY) && (r_count == CNT_W'(WIDTH - 1));
    w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_mc     <= 1'b0;
      r_mv     <= 1'b0;
    end else if (w_accept && w_is_mul) begin
      r_acc    <= '0;
      r_mcand  <= in1;
      r_mplier <= in2;
      r_count  <= '0;
      r_mc     <= c_in;
      r_mv     <= v_in;
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
    end
  end
`else
  always_comb begin
    in_ready = (!r_out_valid || out_ready) && !flush;
    dbg_busy = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_sr        <= 4'b0100;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_sr        <= w_sr;
`ifdef ALU_SEQ_MUL_EN
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_acc_nxt;
      r_sr        <= {w_acc_nxt[WIDTH-1], (w_acc_nxt == '0), r_mc, r_mv};
`endif
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit (WIDTH=32): vector table plus hand-written multi-cycle sequences.
module tb_alu_seq_unit;
  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, c_in, v_in, dbg_busy;
  logic [3:0]  exe_cmd, sr;
  logic [31:0] in1, in2, result;

  int n_cmp = 0;
  int n_err = 0;
  logic [35:0] exp_q[$];
  logic [35:0] cur_exp;

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic        v;
    logic [31:0] exp_res;
    logic [3:0]  exp_sr;
  } vec_t;
  vec_t vecs[16];
  int   n_vec = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(WIDTH), .CMD_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .exe_cmd(exe_cmd), .in1(in1), .in2(in2), .c_in(c_in), .v_in(v_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .sr(sr), .dbg_busy(dbg_busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic c, input logic v,
                         input logic [31:0] er, input logic [3:0] es);
    vecs[n_vec] = '{name, cmd, a, b, c, v, er, es};
    n_vec++;
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic v);
    in_valid = 1'b1;
    exe_cmd  = cmd;
    in1      = a;
    in2      = b;
    c_in     = c;
    v_in     = v;
  endtask

  // Scoreboard step: checks the output leaving on this edge and queues the op entering on it.
  task automatic clk_step();
    logic        xfer, acc;
    logic [35:0] snap;
    xfer = out_valid && out_ready;
    acc  = in_valid && in_ready;
    snap = {result, sr};
    if (xfer) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_spurious: actual=%h required=none", snap);
      end else begin
        chk("sb_order", snap, exp_q.pop_front());
      end
    end
    if (acc) exp_q.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, busy_bad, seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exe_cmd = '0; in1 = '0; in2 = '0; c_in = 1'b0; v_in = 1'b0;

    add_vec("add_ovf",  4'h2, 32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 4'b1001);
    add_vec("sub_eq",   4'h4, 32'h00000005, 32'h00000005, 0, 0, 32'h00000000, 4'b0110);
    add_vec("sub_brw",  4'h4, 32'h00000000, 32'h00000001, 0, 0, 32'hFFFFFFFF, 4'b1000);
    add_vec("sbc_c0",   4'h5, 32'h00000005, 32'h00000003, 0, 0, 32'h00000001, 4'b0010);
    add_vec("undef_f",  4'hF, 32'h12345678, 32'h9ABCDEF0, 1, 0, 32'h00000000, 4'b0110);
    add_vec("mov_zero", 4'h1, 32'hDEADBEEF, 32'h00000000, 1, 1, 32'h00000000, 4'b0111);
    add_vec("mvn",      4'h9, 32'h00000000, 32'h00000000, 0, 1, 32'hFFFFFFFF, 4'b1001);
    add_vec("adc_wrap", 4'h3, 32'hFFFFFFFF, 32'h00000000, 1, 0, 32'h00000000, 4'b0110);
    add_vec("and",      4'h6, 32'hF0F0F0F0, 32'hFF00FF00, 0, 1, 32'hF000F000, 4'b1001);
    add_vec("orr",      4'h7, 32'h0000000F, 32'h000000F0, 1, 0, 32'h000000FF, 4'b0010);
    add_vec("eor_zero", 4'h8, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 32'h00000000, 4'b0100);
    add_vec("add_neg",  4'h2, 32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 4'b0111);
    add_vec("undef_0",  4'h0, 32'h00000011, 32'h00000022, 0, 1, 32'h00000000, 4'b0101);
    add_vec("sub_vovf", 4'h4, 32'h80000000, 32'h00000001, 0, 0, 32'h7FFFFFFF, 4'b0011);
`ifndef ALU_SEQ_MUL_EN
    add_vec("mul_off",  4'hA, 32'h0000FFFF, 32'h00010001, 0, 0, 32'h00000000, 4'b0100);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {35'd0, out_valid}, 36'd0);
    chk("rst_result", {4'd0, result}, 36'd0);
    chk("rst_sr", {32'd0, sr}, 36'h4);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {35'd0, in_ready}, 36'd1);

    // Table: back-to-back single-cycle ops, consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < n_vec; i++) begin
      drive(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].v);
      #1;
      chk({vecs[i].name, "_ready"}, {35'd0, in_ready}, 36'd1);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_valid"}, {35'd0, out_valid}, 36'd1);
      chk({vecs[i].name, "_res"}, {4'd0, result}, {4'd0, vecs[i].exp_res});
      chk({vecs[i].name, "_sr"}, {32'd0, sr}, {32'd0, vecs[i].exp_sr});
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_valid", {35'd0, out_valid}, 36'd0);

    // Back-pressure: ADD, EOR, MOV with out_ready low for two cycles.
    out_ready = 1'b0;
    drive(4'h2, 32'd3, 32'd4, 0, 0);
    cur_exp = {32'd7, 4'b0000};
    #1;
    clk_step();
    drive(4'h8, 32'h000000F0, 32'h0000000F, 0, 0);
    cur_exp = {32'h000000FF, 4'b0000};
    #1;
    chk("bp_ready_lo1", {35'd0, in_ready}, 36'd0);
    clk_step();
    chk("bp_ready_lo2", {35'd0, in_ready}, 36'd0);
    chk("bp_hold", {result, sr}, {32'd7, 4'b0000});
    clk_step();
    out_ready = 1'b1;
    #1;
    clk_step();
    drive(4'h1, 32'h0, 32'h00001234, 1, 0);
    cur_exp = {32'h00001234, 4'b0010};
    #1;
    clk_step();
    in_valid = 1'b0;
    #1;
    clk_step();
    clk_step();
    chk("bp_all_out", {4'd0, 32'(exp_q.size())}, 36'd0);
    chk("bp_idle", {35'd0, out_valid}, 36'd0);

    // Operands captured at accept; later input changes must not affect the held result.
    out_ready = 1'b0;
    drive(4'h2, 32'd10, 32'd20, 0, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in1 = 32'hFFFFFFFF;
    exe_cmd = 4'h9;
    @(posedge clk);
    #1;
    chk("capture_hold", {result, sr}, {32'd30, 4'b0000});

    // Flush drops a pending output and blocks the op presented with it.
    flush = 1'b1;
    drive(4'h4, 32'd9, 32'd1, 0, 0);
    #1;
    chk("flush_in_ready", {35'd0, in_ready}, 36'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_drop", {35'd0, out_valid}, 36'd0);
    #1;
    chk("flush_ready_after", {35'd0, in_ready}, 36'd1);
    @(posedge clk);
    #1;
    chk("flush_no_accept", {35'd0, out_valid}, 36'd0);

    // Asynchronous reset clears a held result without waiting for an edge.
    drive(4'h2, 32'd7, 32'd8, 0, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {35'd0, out_valid}, 36'd0);
    chk("arst_result", {result, sr}, {32'd0, 4'b0100});
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef ALU_SEQ_MUL_EN
    out_ready = 1'b1;
    drive(4'hA, 32'h0000FFFF, 32'h00010001, 1, 0);
    #1;
    chk("mul_ready", {35'd0, in_ready}, 36'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in1 = 32'h0;
    lat = 1;
    busy_bad = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready !== 1'b0 || dbg_busy !== 1'b1) busy_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("mul_latency", {4'd0, 32'(lat)}, 36'd33);
    chk("mul_busy_ready", {4'd0, 32'(busy_bad)}, 36'd0);
    chk("mul_result", {result, sr}, {32'hFFFFFFFF, 4'b1010});

    drive(4'hA, 32'd3, 32'd5, 0, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("mulflush_ready", {34'd0, in_ready, dbg_busy}, 36'd2);
    seen = 0;
    repeat (40) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    chk("mulflush_no_valid", {4'd0, 32'(seen)}, 36'd0);

    drive(4'hA, 32'd3, 32'd5, 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mulrst_state", {34'd0, dbg_busy, out_valid}, 36'd0);
    chk("mulrst_out", {result, sr}, {32'd0, 4'b0100});
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mulrst_ready", {35'd0, in_ready}, 36'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
